// File: rtl/count_ctrl.sv
// count_ctrl: Wishbone-programmable count register with prescaled run engine, compare/overflow irq.
// Optional macro COUNT_CTRL_ONESHOT_EN adds CTRL[4] oneshot (run stops on a step that hits COMPARE).
module count_ctrl #(
   parameter int unsigned BITS       = 32,
   parameter int unsigned PRESC_BITS = 8,
   parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   input  logic            la_load,
   input  logic [BITS-1:0] la_value,
   output logic [BITS-1:0] count_o,
   output logic            irq_o
);
   localparam logic [1:0] REG_COUNT  = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_CMP    = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   logic [BITS-1:0]       count_q, count_d, compare_q, compare_d;
   logic                  run_q, run_d, dir_q, dir_d, wrap_q, wrap_d, irq_en_q, irq_en_d;
   logic [PRESC_BITS-1:0] presc_q, presc_d, psc_q, psc_d;
   logic                  match_q, match_d, ovf_q, ovf_d;
   logic                  ack_q, ack_d, irq_q, irq_d;
   logic [31:0]           dat_q, dat_d;
   logic                  oneshot_c;

   logic                  hit_c, wr_c;
   logic [1:0]            idx_c, w1c_c;
   logic [31:0]           mask_c, rd_c, merged_c, ctrl_rd_c;
   logic                  tick_c, at_end_c, run_clr_c, step_win_c, match_set_c, ovf_set_c;
   logic [BITS-1:0]       step_val_c;
   logic                  unused_c;

   assign unused_c = ^wbs_adr_i[1:0];

   // Bus decode; a hit is refused while ack is still high so a held strobe acks every other cycle.
   assign hit_c  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]) & ~ack_q;
   assign wr_c   = hit_c & wbs_we_i;
   assign idx_c  = wbs_adr_i[3:2];
   assign mask_c = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

   assign ctrl_rd_c = {16'h0000, 8'(presc_q), 3'b000, oneshot_c, irq_en_q, wrap_q, dir_q, run_q};

   always_comb begin
      rd_c = 32'h0;
      case (idx_c)
         REG_COUNT:  rd_c = 32'(count_q);
         REG_CTRL:   rd_c = ctrl_rd_c;
         REG_CMP:    rd_c = 32'(compare_q);
         REG_STATUS: rd_c = {30'h0, ovf_q, match_q};
         default:    rd_c = 32'h0;
      endcase
   end

   assign merged_c = (rd_c & ~mask_c) | (wbs_dat_i & mask_c);
   assign w1c_c    = (wr_c && idx_c == REG_STATUS) ? (wbs_dat_i[1:0] & {2{wbs_sel_i[0]}}) : 2'b00;

   // Run engine: prescaler spans 0..presc, tick on the terminal value.
   assign tick_c     = run_q && (psc_q == presc_q);
   assign psc_d      = (run_q && !tick_c) ? psc_q + PRESC_BITS'(1) : '0;
   assign at_end_c   = dir_q ? (count_q == '0) : (count_q == '1);
   assign step_val_c = dir_q ? count_q - BITS'(1) : count_q + BITS'(1);

`ifdef COUNT_CTRL_ONESHOT_EN
   logic oneshot_q, oneshot_d;

   always_comb begin
      oneshot_d = oneshot_q;
      if (wr_c && idx_c == REG_CTRL) oneshot_d = merged_c[4];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) oneshot_q <= 1'b0;
      else       oneshot_q <= oneshot_d;
   end

   assign oneshot_c = oneshot_q;
`else
   assign oneshot_c = 1'b0;
`endif

   always_comb begin
      count_d     = count_q;
      compare_d   = compare_q;
      run_d       = run_q;
      dir_d       = dir_q;
      wrap_d      = wrap_q;
      irq_en_d    = irq_en_q;
      presc_d     = presc_q;
      run_clr_c   = 1'b0;
      step_win_c  = 1'b0;
      ovf_set_c   = 1'b0;
      match_set_c = 1'b0;

      // One count source per edge: bus write, then LA load, then run step.
      if (wr_c && idx_c == REG_COUNT) begin
         count_d = BITS'(merged_c);
      end else if (la_load) begin
         count_d = la_value;
      end else if (tick_c) begin
         step_win_c = 1'b1;
         if (!at_end_c || wrap_q) count_d = step_val_c;
         if (at_end_c) begin
            ovf_set_c = 1'b1;
            run_clr_c = ~wrap_q;
         end
      end

      match_set_c = (count_d != count_q) && (count_d == compare_q);
      if (oneshot_c && step_win_c && match_set_c) run_clr_c = 1'b1;

      if (wr_c && idx_c == REG_CTRL) begin
         run_d    = merged_c[0];
         dir_d    = merged_c[1];
         wrap_d   = merged_c[2];
         irq_en_d = merged_c[3];
         presc_d  = PRESC_BITS'(merged_c[15:8]);
      end else if (run_clr_c) begin
         run_d = 1'b0;
      end

      if (wr_c && idx_c == REG_CMP) compare_d = BITS'(merged_c);

      match_d = match_set_c | (match_q & ~w1c_c[0]);
      ovf_d   = ovf_set_c   | (ovf_q   & ~w1c_c[1]);
   end

   assign ack_d = hit_c;
   assign dat_d = hit_c ? rd_c : dat_q;
   assign irq_d = irq_en_q & (match_q | ovf_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= '0;
         run_q     <= 1'b0;
         dir_q     <= 1'b0;
         wrap_q    <= 1'b0;
         irq_en_q  <= 1'b0;
         presc_q   <= '0;
         psc_q     <= '0;
         match_q   <= 1'b0;
         ovf_q     <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= 32'h0;
         irq_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         run_q     <= run_d;
         dir_q     <= dir_d;
         wrap_q    <= wrap_d;
         irq_en_q  <= irq_en_d;
         presc_q   <= presc_d;
         psc_q     <= psc_d;
         match_q   <= match_d;
         ovf_q     <= ovf_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         irq_q     <= irq_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign count_o   = count_q;
   assign irq_o     = irq_q;

endmodule
